filtd_scale_filter: RTL and testbench



---
 rtl/adpcm_pkg.sv | 22 ++
 rtl/filtd_core.sv | 24 ++
 rtl/filtd_scale_filter.sv | 34 +++
 tb/tb_filtd_scale_filter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/adpcm_pkg.sv
// Shared ADPCM adaptation-path word types and constants.
// Used by FUNCTW, FILTD and LIMB stages; holds no logic of its own.
// No flow control: purely type and constant definitions.
package adpcm_pkg;

  // Word widths fixed by the G.726 bit-exact definition.
  localparam int WI_W  = 12;
  localparam int Y_W   = 13;
  localparam int DIF_W = 17;

  // Arithmetic constants of the scale-factor filter.
  localparam int DIF_OFFSET = 131072;
  localparam int DIF_MASK   = 131071;
  localparam int SIGN_EXT   = 4096;
  localparam int Y_MASK     = 8191;

  // Log scale-factor multiplier (two's complement) and scale factor (unsigned).
  typedef logic [WI_W-1:0]  wi_t;
  typedef logic [Y_W-1:0]   y_t;
  typedef logic [DIF_W-1:0] dif_t;

endpackage

// File: rtl/filtd_core.sv
// Fast scale-factor filter arithmetic: YUT_next = Y + ((WI*32 - Y) >>> 5) mod 2^13.
// Latency: combinational, zero cycles.
// No flow control: output follows the inputs continuously.
module filtd_core
  import adpcm_pkg::*;
(
  input  wi_t wi_i,
  input  y_t  y_i,
  output y_t  yut_next_o
);

  dif_t dif;
  y_t   difsx;

  // The +131072 offset is exactly 2^17, so it vanishes in 17-bit arithmetic;
  // the subtract below already yields (WI<<5) + 131072 - Y mod 2^17.
  always_comb begin
    dif        = {wi_i, 5'b0} - {{(DIF_W - Y_W){1'b0}}, y_i};
    // Adding 4096 to DIF[16:5] when DIFS is set is a sign extension to 13 bits.
    difsx      = {dif[DIF_W-1], dif[DIF_W-1:5]};
    yut_next_o = y_i + difsx;
  end

endmodule

// File: rtl/filtd_scale_filter.sv
// Unlocked quantizer scale-factor low-pass filter (FILTD) feeding the LIMB limiter.
// Latency: 1 cycle from WI/Y to YUT; a new result every cycle.
// No handshake: never stalls, output holds between edges; reset clears to 0.
module filtd_scale_filter
  import adpcm_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [WI_W-1:0] WI,
  input  logic [Y_W-1:0]  Y,
  output logic [Y_W-1:0]  YUT
);

  y_t yut_d;
  y_t yut_q;

  filtd_core u_core (
    .wi_i       (WI),
    .y_i        (Y),
    .yut_next_o (yut_d)
  );

  // Output register; reset has priority so unknown inputs during reset never reach YUT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      yut_q <= '0;
    end else begin
      yut_q <= yut_d;
    end
  end

  assign YUT = yut_q;

endmodule

// File: tb/tb_filtd_scale_filter.sv
// Self-checking bench for filtd_scale_filter: directed vectors plus random pairs
// against an arithmetic reference model of the scale-factor filter.
// Inputs change on the falling edge; YUT is checked on the following falling edge.
module tb_filtd_scale_filter;

  logic        clk;
  logic        reset;
  logic [11:0] WI;
  logic [12:0] Y;
  logic [12:0] YUT;

  int checks;
  int errors;

  logic [12:0] exp_yut;
  string       exp_tag;
  bit          exp_vld;

  filtd_scale_filter dut (
    .clk   (clk),
    .reset (reset),
    .WI    (WI),
    .Y     (Y),
    .YUT   (YUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the filter formula in plain integer arithmetic.
  function automatic int model(input int wi, input int y);
    int dif;
    int hi;
    int difsx;
    dif   = (wi * 32 + 131072 - y) % 131072;
    hi    = dif / 32;
    difsx = (dif >= 65536) ? hi + 4096 : hi;
    return (y + difsx) % 8192;
  endfunction

  // One cycle: check the result of the previous cycle's inputs, then apply new ones.
  // want < 0 means take the expected value from the reference model.
  task automatic step(input logic rst, input logic [11:0] wi, input logic [12:0] y,
                      input int want, input string tag);
    int m;
    @(negedge clk);
    if (exp_vld) chk(exp_tag, YUT, exp_yut);
    reset = rst;
    WI    = wi;
    Y     = y;
    if (!rst) m = 0;
    else      m = model(int'(wi), int'(y));
    if (want >= 0) begin
      if (want != m) begin
        errors++;
        checks++;
        $display("FAIL model_%s: got %0d expected %0d", tag, m, want);
      end
      exp_yut = 13'(want);
    end else begin
      exp_yut = 13'(m);
    end
    exp_tag = tag;
    exp_vld = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_vld = 1'b0;
    reset   = 1'b0;
    WI      = 12'h7FF;
    Y       = 13'h1FFF;

    // Reset held two cycles with nonzero inputs, then release with zeros.
    step(1'b0, 12'h7FF, 13'h1FFF, 0, "reset0");
    step(1'b0, 12'h7FF, 13'h1FFF, 0, "reset1");
    step(1'b1, 12'h000, 13'd0,    0, "release_zero");

    // Directed vectors, back-to-back on consecutive cycles.
    step(1'b1, 12'h010, 13'd0,    16,   "wi010_y0");
    step(1'b1, 12'h000, 13'd544,  527,  "wi0_y544");
    step(1'b1, 12'hFFF, 13'd0,    8191, "wiFFF_y0");
    step(1'b1, 12'h7FF, 13'd8191, 1790, "wi7FF_y8191");
    step(1'b1, 12'h800, 13'd8191, 1791, "wi800_y8191");
    step(1'b1, 12'h010, 13'd512,  512,  "dif_zero");
    step(1'b1, 12'h800, 13'd0,    6144, "wi800_y0");

    // Reset mid-stream, with unknown inputs during reset.
    step(1'b0, 12'h123, 13'd77,   0,    "mid_reset");
    step(1'b0, 'x,      'x,       0,    "reset_x_in");
    step(1'b1, 12'h010, 13'd0,    16,   "after_reset");

    // Random pairs, with an occasional reset pulse.
    for (int i = 0; i < 10000; i++) begin
      logic        r;
      logic [11:0] w;
      logic [12:0] yy;
      r  = ($urandom_range(0, 199) != 0);
      w  = 12'($urandom);
      yy = 13'($urandom);
      step(r, w, yy, -1, r ? "random" : "random_reset");
    end

    // Flush the last expected result.
    @(negedge clk);
    if (exp_vld) chk(exp_tag, YUT, exp_yut);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
